// File: rtl/ext_bus_arbiter_pkg.sv
// Shared definitions for the external bus arbiter: bus widths, pin encodings,
// FSM state encoding and a small port-to-one-hot helper.
package ext_bus_arbiter_pkg;

  localparam int unsigned BusAw = 16;
  localparam int unsigned BusDw = 16;

  // Encoding of the external rw pin.
  localparam logic RwRead  = 1'b1;
  localparam logic RwWrite = 1'b0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StWait = 2'd2,
    StDone = 2'd3
  } bus_state_e;

  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ext_bus_arbiter_rr_arb2.sv
// Two-way round-robin arbiter (purely combinational).
// Ports:
//   req_i       per-port request
//   last_i      port served most recently; a tie goes to the other port
//   mask_en_i   restrict grants to mask_port_i (bus lock owner)
//   mask_port_i the only port eligible while mask_en_i is set
//   en_i        allow any grant this cycle
//   gnt_vld_o   a port is granted
//   gnt_port_o  granted port index
module ext_bus_arbiter_rr_arb2
  import ext_bus_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       mask_en_i,
  input  logic       mask_port_i,
  input  logic       en_i,
  output logic       gnt_vld_o,
  output logic       gnt_port_o
);

  logic [1:0] req_eff;

  always_comb begin
    req_eff = req_i & (mask_en_i ? port_onehot(mask_port_i) : 2'b11);
    if (!en_i) begin
      req_eff = 2'b00;
    end
    gnt_vld_o = |req_eff;
    case (req_eff)
      2'b11:   gnt_port_o = ~last_i;
      2'b10:   gnt_port_o = 1'b1;
      default: gnt_port_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ext_bus_arbiter.sv
// External 16-bit bus arbiter. Arbitrates instruction fetch (port 0) and load/store (port 1)
// onto the bus pins, sequences each transfer as ADDR -> WAIT x WAIT_CYCLES -> DONE, and manages
// the shared lock line for locked read-modify-write sequences with an idle timeout.
// Ports:
//   clk, n_rst                      clock, synchronous active-low reset
//   i_m_req/i_m_we/i_m_lock         per-port request, write, keep-locked flags
//   i_m{0,1}_addr, i_m{0,1}_wdata   per-port address / write data
//   o_m_done, o_m_rdata             per-port completion pulse, read data
//   o_rw, o_addr, o_data, o_data_oe external bus drive (tristates resolved at top level)
//   i_data                          external data sample
//   o_lock, o_lock_oe, i_lock       lock line drive / enable / sample
//   o_lock_timeout                  one-cycle pulse on forced lock release
module ext_bus_arbiter
  import ext_bus_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES  = 2,
  parameter int unsigned LOCK_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [1:0]       i_m_req,
  input  logic [1:0]       i_m_we,
  input  logic [1:0]       i_m_lock,
  input  logic [BusAw-1:0] i_m0_addr,
  input  logic [BusAw-1:0] i_m1_addr,
  input  logic [BusDw-1:0] i_m0_wdata,
  input  logic [BusDw-1:0] i_m1_wdata,
  output logic [1:0]       o_m_done,
  output logic [BusDw-1:0] o_m_rdata,
  output logic             o_rw,
  output logic [BusAw-1:0] o_addr,
  output logic [BusDw-1:0] o_data,
  output logic             o_data_oe,
  input  logic [BusDw-1:0] i_data,
  output logic             o_lock,
  output logic             o_lock_oe,
  input  logic             i_lock,
  output logic             o_lock_timeout
);

  localparam int unsigned WaitW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int unsigned CntW  = $clog2(LOCK_TIMEOUT + 1);

  bus_state_e       state_q, state_d;
  logic             port_q, port_d;
  logic             we_q, we_d;
  logic             lock_q, lock_d;
  logic [BusAw-1:0] addr_q, addr_d;
  logic [BusDw-1:0] wdata_q, wdata_d;
  logic [BusDw-1:0] rdata_q, rdata_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             owner_vld_q, owner_vld_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [CntW-1:0]  idle_cnt_q, idle_cnt_d;
  logic             timeout_q, timeout_d;

  logic             arb_en, gnt_vld, gnt_port;
  logic [CntW-1:0]  idle_inc;

  // A foreign agent holding the lock pin blocks us unless we are the ones driving it.
  assign arb_en = (state_q == StIdle) && !(i_lock && !owner_vld_q);

  ext_bus_arbiter_rr_arb2 u_arb (
    .req_i       (i_m_req),
    .last_i      (last_q),
    .mask_en_i   (owner_vld_q),
    .mask_port_i (owner_q),
    .en_i        (arb_en),
    .gnt_vld_o   (gnt_vld),
    .gnt_port_o  (gnt_port)
  );

  // Saturating increment; release happens when it reaches LOCK_TIMEOUT.
  assign idle_inc = (idle_cnt_q >= CntW'(LOCK_TIMEOUT)) ? idle_cnt_q : idle_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    we_d        = we_q;
    lock_d      = lock_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    wait_cnt_d  = wait_cnt_q;
    owner_vld_d = owner_vld_q;
    owner_d     = owner_q;
    last_d      = last_q;
    idle_cnt_d  = idle_cnt_q;
    timeout_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (gnt_vld) begin
          state_d    = StAddr;
          port_d     = gnt_port;
          we_d       = i_m_we[gnt_port];
          lock_d     = i_m_lock[gnt_port];
          addr_d     = gnt_port ? i_m1_addr : i_m0_addr;
          wdata_d    = gnt_port ? i_m1_wdata : i_m0_wdata;
          last_d     = gnt_port;
          wait_cnt_d = '0;
          idle_cnt_d = '0;
          if (i_m_lock[gnt_port]) begin
            owner_vld_d = 1'b1;
            owner_d     = gnt_port;
          end
        end else if (owner_vld_q) begin
          if (idle_inc == CntW'(LOCK_TIMEOUT)) begin
            owner_vld_d = 1'b0;
            idle_cnt_d  = '0;
            timeout_d   = 1'b1;
          end else begin
            idle_cnt_d = idle_inc;
          end
        end
      end
      StAddr: begin
        if (WAIT_CYCLES == 0) begin
          state_d = StDone;
          if (!we_q) rdata_d = i_data;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (wait_cnt_q == WaitW'(WAIT_CYCLES - 1)) begin
          state_d = StDone;
          if (!we_q) rdata_d = i_data;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        // The owner's final transfer of a locked sequence drops the lock.
        if (owner_vld_q && (owner_q == port_q) && !lock_q) begin
          owner_vld_d = 1'b0;
          idle_cnt_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= StIdle;
      port_q      <= 1'b0;
      we_q        <= 1'b0;
      lock_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      wait_cnt_q  <= '0;
      owner_vld_q <= 1'b0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      idle_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      we_q        <= we_d;
      lock_q      <= lock_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      wait_cnt_q  <= wait_cnt_d;
      owner_vld_q <= owner_vld_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      idle_cnt_q  <= idle_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  logic busy;
  assign busy = (state_q != StIdle);

  always_comb begin
    o_rw           = busy ? (we_q ? RwWrite : RwRead) : RwRead;
    o_addr         = addr_q;
    o_data         = wdata_q;
    o_data_oe      = busy && we_q;
    o_lock         = owner_vld_q;
    o_lock_oe      = owner_vld_q;
    o_m_done       = (state_q == StDone) ? port_onehot(port_q) : 2'b00;
    o_m_rdata      = rdata_q;
    o_lock_timeout = timeout_q;
  end

endmodule

// File: tb/tb_ext_bus_arbiter.sv
module tb_ext_bus_arbiter;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [1:0]  req, we, lock;
  logic [15:0] a0, a1, w0, w1, idata;
  logic [1:0]  done;
  logic [15:0] rdata, addr, data;
  logic        rw, data_oe, lock_o, lock_oe, ilock, tmo;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ext_bus_arbiter dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .i_m_req        (req),
    .i_m_we         (we),
    .i_m_lock       (lock),
    .i_m0_addr      (a0),
    .i_m1_addr      (a1),
    .i_m0_wdata     (w0),
    .i_m1_wdata     (w1),
    .o_m_done       (done),
    .o_m_rdata      (rdata),
    .o_rw           (rw),
    .o_addr         (addr),
    .o_data         (data),
    .o_data_oe      (data_oe),
    .i_data         (idata),
    .o_lock         (lock_o),
    .o_lock_oe      (lock_oe),
    .i_lock         (ilock),
    .o_lock_timeout (tmo)
  );

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [15:0] a0, a1, w0, w1, idata;
    logic [1:0]  exp_done;
    logic        exp_rw;
    logic        exp_oe;
    logic [15:0] exp_addr;
    logic [15:0] exp_data;  // o_data for writes, o_m_rdata for reads
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(input logic [1:0] r, input logic [1:0] w, input logic [15:0] x0,
                              input logic [15:0] x1, input logic [15:0] d0,
                              input logic [15:0] d1, input logic [15:0] id,
                              input logic [1:0] ed, input logic erw, input logic eoe,
                              input logic [15:0] ea, input logic [15:0] edat);
    vec_t v;
    v.req = r; v.we = w; v.a0 = x0; v.a1 = x1; v.w0 = d0; v.w1 = d1; v.idata = id;
    v.exp_done = ed; v.exp_rw = erw; v.exp_oe = eoe; v.exp_addr = ea; v.exp_data = edat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    req = 2'b00; we = 2'b00; lock = 2'b00; ilock = 1'b0;
    a0 = '0; a1 = '0; w0 = '0; w1 = '0; idata = '0;
    tick();
    tick();
    n_rst = 1'b1;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    req = v.req; we = v.we; lock = 2'b00;
    a0 = v.a0; a1 = v.a1; w0 = v.w0; w1 = v.w1; idata = v.idata;
    tick();  // ADDR
    chk($sformatf("v%0d addr", i), addr, v.exp_addr);
    chk($sformatf("v%0d rw", i), rw, v.exp_rw);
    chk($sformatf("v%0d oe", i), data_oe, v.exp_oe);
    if (v.exp_oe) chk($sformatf("v%0d wdata", i), data, v.exp_data);
    chk($sformatf("v%0d early done", i), done, 2'b00);
    tick();
    tick();  // last WAIT
    chk($sformatf("v%0d addr held", i), addr, v.exp_addr);
    chk($sformatf("v%0d oe held", i), data_oe, v.exp_oe);
    chk($sformatf("v%0d wait done", i), done, 2'b00);
    tick();  // DONE
    chk($sformatf("v%0d done", i), done, v.exp_done);
    chk($sformatf("v%0d oe at done", i), data_oe, v.exp_oe);
    if (!v.exp_oe) chk($sformatf("v%0d rdata", i), rdata, v.exp_data);
    tick();  // IDLE
    req = 2'b00;
    chk($sformatf("v%0d done clr", i), done, 2'b00);
    chk($sformatf("v%0d oe clr", i), data_oe, 1'b0);
    chk($sformatf("v%0d rw idle", i), rw, 1'b1);
  endtask

  initial begin
    logic [1:0] order[4];
    int         n_done;
    int         k_tmo;

    vecs[0] = mk(2'b01, 2'b00, 16'h1234, 16'h9999, 16'h0000, 16'h0000, 16'hBEEF,
                 2'b01, 1'b1, 1'b0, 16'h1234, 16'hBEEF);
    vecs[1] = mk(2'b10, 2'b10, 16'h0000, 16'h0010, 16'h0000, 16'h5A5A, 16'h0000,
                 2'b10, 1'b0, 1'b1, 16'h0010, 16'h5A5A);
    vecs[2] = mk(2'b11, 2'b00, 16'h0A0A, 16'h0B0B, 16'h0000, 16'h0000, 16'h1111,
                 2'b01, 1'b1, 1'b0, 16'h0A0A, 16'h1111);
    vecs[3] = mk(2'b11, 2'b11, 16'h2222, 16'h3333, 16'hAAAA, 16'h5555, 16'h0000,
                 2'b10, 1'b0, 1'b1, 16'h3333, 16'h5555);
    vecs[4] = mk(2'b11, 2'b01, 16'h4444, 16'h6666, 16'hC3C3, 16'h0000, 16'h0000,
                 2'b01, 1'b0, 1'b1, 16'h4444, 16'hC3C3);
    vecs[5] = mk(2'b10, 2'b00, 16'h7777, 16'hFFFF, 16'h0000, 16'h0000, 16'h8001,
                 2'b10, 1'b1, 1'b0, 16'hFFFF, 16'h8001);

    // Reset state
    do_reset();
    chk("rst rw", rw, 1'b1);
    chk("rst addr", addr, 16'h0000);
    chk("rst data", data, 16'h0000);
    chk("rst oe", data_oe, 1'b0);
    chk("rst lock", lock_o, 1'b0);
    chk("rst lock_oe", lock_oe, 1'b0);
    chk("rst done", done, 2'b00);
    chk("rst rdata", rdata, 16'h0000);
    chk("rst timeout", tmo, 1'b0);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Continuous requests from reset: strict alternation starting with port 0.
    do_reset();
    req = 2'b11; we = 2'b00; a0 = 16'h00A0; a1 = 16'h00B1;
    n_done = 0;
    for (int c = 0; c < 40 && n_done < 4; c++) begin
      tick();
      if (done != 2'b00) begin
        order[n_done] = done;
        n_done++;
      end
    end
    req = 2'b00;
    chk("alt count", n_done, 4);
    for (int k = 0; k < n_done; k++)
      chk($sformatf("alt order %0d", k), order[k], (k % 2 == 0) ? 2'b01 : 2'b10);

    // Locked RMW on port 1 with port 0 pending.
    do_reset();
    req = 2'b10; we = 2'b00; lock = 2'b10; a1 = 16'h0100; a0 = 16'h0200; idata = 16'h7777;
    tick();
    chk("rmw rd addr", addr, 16'h0100);
    chk("rmw lock_oe addr", lock_oe, 1'b1);
    chk("rmw lock addr", lock_o, 1'b1);
    req = 2'b11;
    tick(); tick(); tick();
    chk("rmw rd done", done, 2'b10);
    chk("rmw rd rdata", rdata, 16'h7777);
    tick();
    req = 2'b01;
    chk("rmw gap lock_oe", lock_oe, 1'b1);
    tick();
    chk("rmw blocked addr", addr, 16'h0100);
    chk("rmw blocked rw", rw, 1'b1);
    req = 2'b11; we = 2'b10; lock = 2'b00; w1 = 16'h7778;
    tick();
    chk("rmw wr addr", addr, 16'h0100);
    chk("rmw wr rw", rw, 1'b0);
    chk("rmw wr data", data, 16'h7778);
    tick(); tick(); tick();
    chk("rmw wr done", done, 2'b10);
    chk("rmw lock_oe at done", lock_oe, 1'b1);
    tick();
    req = 2'b01; we = 2'b00;
    chk("rmw lock released", lock_oe, 1'b0);
    tick();
    chk("rmw p0 addr", addr, 16'h0200);
    chk("rmw p0 rw", rw, 1'b1);
    tick(); tick(); tick();
    chk("rmw p0 done", done, 2'b01);
    tick();
    req = 2'b00;

    // Lock owner goes idle: forced release after 64 idle cycles.
    do_reset();
    req = 2'b10; we = 2'b00; lock = 2'b10; a1 = 16'h0300; a0 = 16'h0400;
    tick(); tick(); tick(); tick();
    chk("tmo owner done", done, 2'b10);
    tick();
    req = 2'b01; lock = 2'b00;
    k_tmo = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (tmo) begin
        k_tmo = k;
        break;
      end
    end
    chk("tmo idle cycles", k_tmo, 64);
    chk("tmo lock_oe", lock_oe, 1'b0);
    chk("tmo lock", lock_o, 1'b0);
    tick();
    chk("tmo pulse width", tmo, 1'b0);
    chk("tmo p0 addr", addr, 16'h0400);
    tick(); tick(); tick();
    chk("tmo p0 done", done, 2'b01);
    tick();
    req = 2'b00;

    // Foreign lock holder blocks grants; reset mid-WAIT aborts the transfer.
    do_reset();
    ilock = 1'b1; req = 2'b01; we = 2'b01; a0 = 16'h0500; w0 = 16'h1357;
    n_done = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done != 2'b00 || rw != 1'b1) n_done++;
    end
    chk("foreign no grant", n_done, 0);
    chk("foreign addr", addr, 16'h0000);
    ilock = 1'b0;
    tick();
    chk("post-foreign addr", addr, 16'h0500);
    chk("post-foreign oe", data_oe, 1'b1);
    chk("post-foreign data", data, 16'h1357);
    tick();
    chk("wait oe", data_oe, 1'b1);
    n_rst = 1'b0;
    tick();
    chk("abort done", done, 2'b00);
    chk("abort oe", data_oe, 1'b0);
    chk("abort lock_oe", lock_oe, 1'b0);
    chk("abort rw", rw, 1'b1);
    chk("abort addr", addr, 16'h0000);
    n_rst = 1'b1;
    req = 2'b00;
    n_done = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done != 2'b00) n_done++;
    end
    chk("abort no late done", n_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
